// File: rtl/quad_enc_pkg.sv
// Shared types and helpers for the rotary-encoder front end.
//   pulse_state_t : output pulse FSM states
//   PEND_MAX      : saturation limit of the signed pending-detent count
//   quad_step     : decodes a prev/cur quadrature pair into {err, signed step}
package quad_enc_pkg;

    typedef enum logic [1:0] {IDLE, INC, DEC, GAP} pulse_state_t;

    localparam int PEND_MAX = 7;

    // Gray position along 00->01->11->10 is converted to binary so a step is
    // just the modulo-4 difference: 1 = +1, 3 = -1, 2 = jumped a phase (error).
    function automatic logic [2:0] quad_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] p_bin;
        logic [1:0] c_bin;
        logic [1:0] diff;
        p_bin = {prev[1], prev[1] ^ prev[0]};
        c_bin = {cur[1], cur[1] ^ cur[0]};
        diff  = c_bin - p_bin;
        case (diff)
            2'd0:    quad_step = 3'b0_00;
            2'd1:    quad_step = 3'b0_01;
            2'd3:    quad_step = 3'b0_11;
            default: quad_step = 3'b1_00;
        endcase
    endfunction

endpackage

// File: rtl/quad_enc_ctrl_debounce.sv
// debounce_ch: 2-flop synchroniser plus level debouncer for one raw channel.
//   clk, rst : clock, asynchronous active-high reset
//   raw      : asynchronous input level
//   db       : debounced level, changes only after DEBOUNCE_CYCLES
//              consecutive synchronised samples differ from it
module debounce_ch
    import quad_enc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b00;
            db   <= 1'b0;
            cnt  <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/quad_enc_ctrl.sv
// quad_enc_ctrl: quadrature encoder front end for the PWM duty adjust inputs.
//   clk, rst     : clock, asynchronous active-high reset
//   enc_a, enc_b : raw encoder channels (asynchronous)
//   inc, dec     : registered detent pulses, PULSE_CYCLES high then at least
//                  PULSE_CYCLES low, never high together
//   quad_err     : one-cycle flag for an illegal two-bit transition
module quad_enc_ctrl
    import quad_enc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 16,
    parameter int STEPS_PER_DETENT = 4,
    parameter int PULSE_CYCLES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enc_a,
    input  logic enc_b,
    output logic inc,
    output logic dec,
    output logic quad_err
);

    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam logic [PW-1:0]      P_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic signed [4:0]  S_POS  = 5'(STEPS_PER_DETENT);
    localparam logic signed [4:0]  S_NEG  = -S_POS;
    localparam logic signed [4:0]  P_HI   = 5'(PEND_MAX);
    localparam logic signed [4:0]  P_LO   = -P_HI;

    logic              a_db, b_db;
    logic [1:0]        prev;
    logic signed [3:0] acc, acc_nxt;
    logic signed [3:0] pending, pend_nxt;
    logic signed [4:0] acc_sum, pend_sum;
    logic [2:0]        qs;
    logic signed [1:0] step, ev, cons;
    pulse_state_t      state;
    logic [PW-1:0]     pcnt;

    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_a (
        .clk(clk), .rst(rst), .raw(enc_a), .db(a_db)
    );
    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_b (
        .clk(clk), .rst(rst), .raw(enc_b), .db(b_db)
    );

    always_comb begin
        qs   = quad_step(prev, {a_db, b_db});
        step = qs[1:0];

        // A full detent's worth of steps in either direction wraps to 0 and
        // emits one event; anything short of that just moves acc.
        acc_sum = {acc[3], acc} + {{3{step[1]}}, step};
        acc_nxt = acc_sum[3:0];
        ev      = 2'b00;
        if (acc_sum == S_POS) begin
            acc_nxt = 4'sd0;
            ev      = 2'b01;
        end else if (acc_sum == S_NEG) begin
            acc_nxt = 4'sd0;
            ev      = 2'b11;
        end

        // The FSM consumes one pending detent in the same cycle it leaves IDLE.
        cons = 2'b00;
        if (state == IDLE) begin
            if (pending > 4'sd0)      cons = 2'b01;
            else if (pending < 4'sd0) cons = 2'b11;
        end

        // Event and consume both apply; clamping drops an event at saturation.
        pend_sum = {pending[3], pending} + {{3{ev[1]}}, ev} - {{3{cons[1]}}, cons};
        if (pend_sum > P_HI)      pend_nxt = P_HI[3:0];
        else if (pend_sum < P_LO) pend_nxt = P_LO[3:0];
        else                      pend_nxt = pend_sum[3:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev     <= 2'b00;
            acc      <= 4'sd0;
            pending  <= 4'sd0;
            quad_err <= 1'b0;
        end else begin
            prev     <= {a_db, b_db};
            acc      <= acc_nxt;
            pending  <= pend_nxt;
            quad_err <= qs[2];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            inc   <= 1'b0;
            dec   <= 1'b0;
            pcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pcnt <= '0;
                    if (pending > 4'sd0) begin
                        state <= INC;
                        inc   <= 1'b1;
                    end else if (pending < 4'sd0) begin
                        state <= DEC;
                        dec   <= 1'b1;
                    end
                end
                INC, DEC: begin
                    if (pcnt == P_LAST) begin
                        inc   <= 1'b0;
                        dec   <= 1'b0;
                        pcnt  <= '0;
                        state <= GAP;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                GAP: begin
                    if (pcnt == P_LAST) begin
                        pcnt  <= '0;
                        state <= IDLE;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    inc   <= 1'b0;
                    dec   <= 1'b0;
                    pcnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_enc_ctrl.sv
// Self-checking bench for quad_enc_ctrl. dut uses 4/4/2 settings; dut2 uses
// one step per detent and long pulses so the pending count can saturate.
module tb_quad_enc_ctrl;
    import quad_enc_pkg::*;

    localparam int DC  = 4;
    localparam int SPD = 4;
    localparam int PC  = 2;
    localparam int PC2 = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enc_a = 1'b0, enc_b = 1'b0, a2 = 1'b0, b2 = 1'b0;
    logic inc, dec, quad_err, inc2, dec2, qerr2;

    always #5 clk = ~clk;

    quad_enc_ctrl #(.DEBOUNCE_CYCLES(DC), .STEPS_PER_DETENT(SPD), .PULSE_CYCLES(PC)) dut (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b),
        .inc(inc), .dec(dec), .quad_err(quad_err)
    );
    quad_enc_ctrl #(.DEBOUNCE_CYCLES(DC), .STEPS_PER_DETENT(1), .PULSE_CYCLES(PC2)) dut2 (
        .clk(clk), .rst(rst), .enc_a(a2), .enc_b(b2),
        .inc(inc2), .dec(dec2), .quad_err(qerr2)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- output monitor (negedge sampling) ----------------
    logic mon_clr = 1'b0;
    logic act_q = 1'b0, err_q = 1'b0, inc2_q = 1'b0;
    int inc_n = 0, dec_n = 0, err_n = 0, err_long = 0, width_bad = 0, gap_bad = 0;
    int overlap = 0, hi_run = 0, low_run = 1000, inc2_n = 0, dec2_n = 0, err2_n = 0, peak2 = 0;
    int pulse_q[$];

    always @(negedge clk) begin
        act_q  <= inc | dec;
        err_q  <= quad_err;
        inc2_q <= inc2;
        if (mon_clr) begin
            inc_n <= 0; dec_n <= 0; err_n <= 0; err_long <= 0; width_bad <= 0;
            gap_bad <= 0; overlap <= 0; hi_run <= 0; low_run <= 1000;
            inc2_n <= 0; dec2_n <= 0; err2_n <= 0; peak2 <= 0;
            pulse_q.delete();
        end else begin
            if (inc && dec) overlap <= overlap + 1;
            if ((inc || dec) && !act_q) begin
                if (inc) begin inc_n <= inc_n + 1; pulse_q.push_back(1); end
                if (dec) begin dec_n <= dec_n + 1; pulse_q.push_back(-1); end
                if (low_run < PC) gap_bad <= gap_bad + 1;
                hi_run <= 1;
            end else if ((inc || dec) && act_q) begin
                hi_run <= hi_run + 1;
            end else if (act_q) begin
                if (hi_run != PC) width_bad <= width_bad + 1;
                low_run <= 1;
            end else if (low_run < 1000) begin
                low_run <= low_run + 1;
            end
            if (quad_err) begin
                err_n <= err_n + 1;
                if (err_q) err_long <= err_long + 1;
            end
            if (inc2 && !inc2_q) inc2_n <= inc2_n + 1;
            if (dec2) dec2_n <= dec2_n + 1;
            if (qerr2) err2_n <= err2_n + 1;
            if (int'(dut2.pending) > peak2) peak2 <= int'(dut2.pending);
        end
    end

    // ---------------- behavioural reference model ----------------
    int m_acc = 0;
    int m_err = 0;
    int m_det_q[$];
    logic [1:0] m_ab = 2'b00;

    // position of a level along the clockwise cycle 00,01,11,10
    function automatic int gpos(input logic [1:0] g);
        case (g)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gray(input int p);
        case (p % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic int det_count(input int v);
        int n = 0;
        foreach (m_det_q[i]) if (m_det_q[i] == v) n++;
        return n;
    endfunction

    task automatic drive_ab(input logic [1:0] ab, input int hold);
        int d;
        d = (gpos(ab) - gpos(m_ab) + 4) % 4;
        if (d == 1) m_acc++;
        else if (d == 3) m_acc--;
        else if (d == 2) m_err++;
        if (m_acc == SPD) begin m_det_q.push_back(1); m_acc = 0; end
        else if (m_acc == -SPD) begin m_det_q.push_back(-1); m_acc = 0; end
        m_ab = ab;
        {enc_a, enc_b} = ab;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
        m_det_q.delete();
        m_err = 0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        enc_a = 1'b0; enc_b = 1'b0; a2 = 1'b0; b2 = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (inc !== 1'b0) begin fails++; $display("FAIL reset_inc: got %b expected 0", inc); end
        tests++; if (dec !== 1'b0) begin fails++; $display("FAIL reset_dec: got %b expected 0", dec); end
        tests++; if (quad_err !== 1'b0) begin fails++; $display("FAIL reset_quad_err: got %b expected 0", quad_err); end
        tests++; if (dut.pending !== 4'sd0 || dut.acc !== 4'sd0) begin
            fails++; $display("FAIL reset_acc_pend: got acc %0d pend %0d expected 0 0", dut.acc, dut.pending);
        end
        tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected IDLE", dut.state); end
        rst = 1'b0;
        m_acc = 0; m_ab = 2'b00;
        clear_mon();
    endtask

    task automatic test_cw_detent();
        clear_mon();
        drive_ab(2'b01, 20); drive_ab(2'b11, 20); drive_ab(2'b10, 20); drive_ab(2'b00, 20);
        repeat (10) @(posedge clk); #1;
        tests++; if (inc_n !== det_count(1)) begin fails++; $display("FAIL cw_inc_count: got %0d expected %0d", inc_n, det_count(1)); end
        tests++; if (dec_n !== det_count(-1)) begin fails++; $display("FAIL cw_dec_count: got %0d expected %0d", dec_n, det_count(-1)); end
        tests++; if (err_n !== m_err) begin fails++; $display("FAIL cw_quad_err: got %0d expected %0d", err_n, m_err); end
        tests++; if (width_bad !== 0) begin fails++; $display("FAIL cw_pulse_width: got %0d bad pulses expected 0", width_bad); end
    endtask

    task automatic test_bounce();
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            enc_a = ~m_ab[1];
            repeat (3) @(posedge clk);
            #1 enc_a = m_ab[1];
            repeat ($urandom_range(3, 8)) @(posedge clk);
            #1;
        end
        repeat (20) @(posedge clk); #1;
        tests++; if (dut.a_db !== m_ab[1]) begin fails++; $display("FAIL bounce_db: got %b expected %b", dut.a_db, m_ab[1]); end
        tests++; if (inc_n + dec_n !== 0) begin fails++; $display("FAIL bounce_pulses: got %0d expected 0", inc_n + dec_n); end
        tests++; if (err_n !== 0) begin fails++; $display("FAIL bounce_quad_err: got %0d expected 0", err_n); end
        tests++; if (int'(dut.acc) !== m_acc) begin fails++; $display("FAIL bounce_acc: got %0d expected %0d", dut.acc, m_acc); end
    endtask

    task automatic test_partial_reversal();
        clear_mon();
        for (int i = 1; i <= 3; i++) drive_ab(gray(gpos(m_ab) + 1), 12);
        tests++; if (int'(dut.acc) !== m_acc) begin fails++; $display("FAIL rev_acc_fwd: got %0d expected %0d", dut.acc, m_acc); end
        for (int i = 1; i <= 3; i++) drive_ab(gray(gpos(m_ab) + 3), 12);
        repeat (10) @(posedge clk); #1;
        tests++; if (int'(dut.acc) !== m_acc) begin fails++; $display("FAIL rev_acc_back: got %0d expected %0d", dut.acc, m_acc); end
        tests++; if (inc_n + dec_n !== m_det_q.size()) begin
            fails++; $display("FAIL rev_pulses: got %0d expected %0d", inc_n + dec_n, m_det_q.size());
        end
    endtask

    task automatic test_illegal();
        clear_mon();
        drive_ab(2'b01, 15);
        drive_ab(2'b10, 15);   // 01 -> 10 skips a phase
        tests++; if (err_n !== m_err) begin fails++; $display("FAIL illegal_err1: got %0d expected %0d", err_n, m_err); end
        tests++; if (int'(dut.acc) !== m_acc) begin fails++; $display("FAIL illegal_acc1: got %0d expected %0d", dut.acc, m_acc); end
        drive_ab(2'b00, 15);
        drive_ab(2'b11, 15);   // 00 -> 11 directly
        tests++; if (err_n !== m_err) begin fails++; $display("FAIL illegal_err2: got %0d expected %0d", err_n, m_err); end
        tests++; if (err_long !== 0) begin fails++; $display("FAIL illegal_err_width: got %0d long flags expected 0", err_long); end
        tests++; if (int'(dut.acc) !== m_acc) begin fails++; $display("FAIL illegal_acc2: got %0d expected %0d", dut.acc, m_acc); end
    endtask

    task automatic test_random_walk();
        int fwd;
        logic seq_ok;
        clear_mon();
        for (int i = 0; i < 48; i++) begin
            fwd = (i < 24) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            drive_ab(gray(gpos(m_ab) + (fwd != 0 ? 1 : 3)), $urandom_range(6, 20));
        end
        repeat (30) @(posedge clk); #1;
        tests++; if (pulse_q.size() !== m_det_q.size()) begin
            fails++; $display("FAIL walk_count: got %0d pulses expected %0d", pulse_q.size(), m_det_q.size());
        end
        seq_ok = (pulse_q.size() == m_det_q.size());
        if (seq_ok) foreach (m_det_q[i]) if (pulse_q[i] != m_det_q[i]) seq_ok = 1'b0;
        tests++; if (seq_ok !== 1'b1) begin fails++; $display("FAIL walk_sequence: got order mismatch flag %b expected 1", seq_ok); end
        tests++; if (width_bad + gap_bad !== 0) begin
            fails++; $display("FAIL walk_shape: got width_bad %0d gap_bad %0d expected 0 0", width_bad, gap_bad);
        end
        tests++; if (overlap !== 0 || err_n !== 0) begin
            fails++; $display("FAIL walk_overlap_err: got overlap %0d err %0d expected 0 0", overlap, err_n);
        end
        tests++; if (int'(dut.acc) !== m_acc) begin fails++; $display("FAIL walk_acc: got %0d expected %0d", dut.acc, m_acc); end
    endtask

    task automatic test_fast_burst();
        clear_mon();
        for (int i = 0; i < 5 * SPD; i++) drive_ab(gray(gpos(m_ab) + 1), 6);
        repeat (30) @(posedge clk); #1;
        tests++; if (inc_n !== det_count(1)) begin fails++; $display("FAIL burst_inc_count: got %0d expected %0d", inc_n, det_count(1)); end
        tests++; if (dec_n !== 0) begin fails++; $display("FAIL burst_dec_count: got %0d expected 0", dec_n); end
        tests++; if (width_bad + gap_bad !== 0) begin
            fails++; $display("FAIL burst_shape: got width_bad %0d gap_bad %0d expected 0 0", width_bad, gap_bad);
        end
    endtask

    // One detent every 6 cycles against one pulse slot every 2*PC2+1 cycles:
    // the queue model below predicts how many detents survive saturation.
    task automatic test_saturation();
        localparam int NEV = 16;
        localparam int GAPC = 6;
        int pend, free_at, total, peak, cons, ev;
        logic [1:0] ab2;
        clear_mon();
        pend = 0; free_at = 0; total = 0; peak = 0;
        for (int t = 0; t < NEV * GAPC + 400; t++) begin
            cons = (t >= free_at && pend > 0) ? 1 : 0;
            ev   = (t % GAPC == 0 && t / GAPC < NEV) ? 1 : 0;
            pend = pend + ev - cons;
            if (pend > PEND_MAX) pend = PEND_MAX;
            if (cons != 0) begin total++; free_at = t + 2 * PC2 + 1; end
            if (pend > peak) peak = pend;
        end
        ab2 = 2'b00;
        for (int i = 0; i < NEV; i++) begin
            ab2 = gray(gpos(ab2) + 1);
            {a2, b2} = ab2;
            repeat (GAPC) @(posedge clk);
            #1;
        end
        repeat (400) @(posedge clk); #1;
        tests++; if (inc2_n !== total) begin fails++; $display("FAIL sat_total_pulses: got %0d expected %0d", inc2_n, total); end
        tests++; if (peak2 !== peak) begin fails++; $display("FAIL sat_peak_pending: got %0d expected %0d", peak2, peak); end
        tests++; if (dec2_n + err2_n !== 0) begin fails++; $display("FAIL sat_dec_err: got %0d expected 0", dec2_n + err2_n); end
    endtask

    task automatic test_reset_mid_pulse();
        int waited;
        clear_mon();
        for (int i = 0; i < SPD - 1; i++) drive_ab(gray(gpos(m_ab) + 1), 8);
        drive_ab(gray(gpos(m_ab) + 1), 1);
        waited = 0;
        while (inc !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        tests++; if (inc !== 1'b1) begin fails++; $display("FAIL midrst_inc_seen: got %b expected 1 within 60 cycles", inc); end
        #2 rst = 1'b1;
        #1;
        tests++; if (inc !== 1'b0 || dec !== 1'b0) begin
            fails++; $display("FAIL midrst_async_drop: got inc %b dec %b expected 0 0", inc, dec);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        m_acc = 0;
        clear_mon();
        repeat (40) @(posedge clk); #1;
        tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL midrst_state: got %0d expected IDLE", dut.state); end
        tests++; if (dut.pending !== 4'sd0) begin fails++; $display("FAIL midrst_pending: got %0d expected 0", dut.pending); end
        tests++; if (inc_n + dec_n !== 0) begin fails++; $display("FAIL midrst_no_pulses: got %0d expected 0", inc_n + dec_n); end
    endtask

    initial begin
        test_reset();
        test_cw_detent();
        test_bounce();
        test_partial_reversal();
        test_illegal();
        test_reset();
        test_random_walk();
        test_reset();
        test_fast_burst();
        test_saturation();
        test_reset_mid_pulse();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
